// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with adjust-by-6 correction; reused serially by the top.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] w_t;

  always_comb begin
    w_t  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s    = w_t[3:0];
    cout = 1'b0;
    if (w_t > {1'b0, BCD_MAX}) begin
      s    = w_t[3:0] + BCD_ADJ;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/accumulator: one digit per clock, LSD first, start/busy/done handshake.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter  int NDIGITS = 4,
  localparam int W       = 4 * NDIGITS
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               start,
  input  logic               clear,
  input  logic               mode,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  output logic               busy,
  output logic               done,
  output logic [W-1:0]       sum,
  output logic               carry_out,
  output logic               error,
  output logic [NDIGITS-1:0] inv_a,
  output logic [NDIGITS-1:0] inv_b
);

  localparam int CW = $clog2(NDIGITS) + 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [W-1:0]       r_opa;
  logic [W-1:0]       r_opb;
  logic [W-1:0]       r_res;
  logic [W-1:0]       r_sum;
  logic               r_c;
  logic               r_cout;
  logic               r_error;
  logic [CW-1:0]      r_cnt;
  logic [NDIGITS-1:0] r_inv_a;
  logic [NDIGITS-1:0] r_inv_b;

  logic [NDIGITS-1:0] w_inv_a;
  logic [NDIGITS-1:0] w_inv_b;
  logic [W-1:0]       w_opb_sel;
  logic [W-1:0]       w_res_shift;
  logic [3:0]         w_digit;
  logic               w_cout;
  logic               w_accept;
  logic               w_last;
  logic               w_any_inv;

  // Accumulate mode feeds back the stored sum, which is always valid BCD, so B flags stay clear.
  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_inv
    assign w_inv_a[gi] = !is_bcd(a[4*gi +: 4]);
    assign w_inv_b[gi] = !mode && !is_bcd(b[4*gi +: 4]);
  end

  assign w_any_inv   = |{w_inv_a, w_inv_b};
  assign w_opb_sel   = mode ? r_sum : b;
  assign w_accept    = (r_state == IDLE) && start && !clear;
  assign w_last      = (r_cnt == CW'(NDIGITS - 1));
  assign w_res_shift = (r_res >> 4) | (W'(w_digit) << (W - 4));

  bcd_digit_add u_digit (
    .a    (r_opa[3:0]),
    .b    (r_opb[3:0]),
    .cin  (r_c),
    .s    (w_digit),
    .cout (w_cout)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_state_next = w_any_inv ? DONE : RUN;
        RUN:     if (w_last) w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_error <= 1'b0;
      r_cnt   <= '0;
      r_inv_a <= '0;
      r_inv_b <= '0;
    end else if (clear) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_error <= 1'b0;
      r_cnt   <= '0;
      r_inv_a <= '0;
      r_inv_b <= '0;
    end else if (w_accept) begin
      r_opa   <= a;
      r_opb   <= w_opb_sel;
      r_inv_a <= w_inv_a;
      r_inv_b <= w_inv_b;
      r_error <= w_any_inv;
      r_c     <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_opa <= r_opa >> 4;
      r_opb <= r_opb >> 4;
      r_res <= w_res_shift;
      r_c   <= w_cout;
      r_cnt <= r_cnt + CW'(1);
      // The visible sum only moves once the whole result has been assembled.
      if (w_last) begin
        r_sum  <= w_res_shift;
        r_cout <= w_cout;
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign error     = r_error;
  assign inv_a     = r_inv_a;
  assign inv_b     = r_inv_b;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomised and directed bench for bcd_serial_adder at NDIGITS = 4, 1 and 8.
module tb_bcd_serial_adder;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        clear = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  start = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  always #5 Clock = ~Clock;

  logic        busy4, done4, cout4, err4;
  logic [15:0] sum4;
  logic [3:0]  inva4, invb4;
  logic        busy1, done1, cout1, err1;
  logic [3:0]  sum1;
  logic [0:0]  inva1, invb1;
  logic        busy8, done8, cout8, err8;
  logic [31:0] sum8;
  logic [7:0]  inva8, invb8;

  bcd_serial_adder #(.NDIGITS(4)) u_dut4 (
    .Clock(Clock), .Resetn(Resetn), .start(start[0]), .clear(clear), .mode(mode),
    .a(a[15:0]), .b(b[15:0]), .busy(busy4), .done(done4), .sum(sum4),
    .carry_out(cout4), .error(err4), .inv_a(inva4), .inv_b(invb4));

  bcd_serial_adder #(.NDIGITS(1)) u_dut1 (
    .Clock(Clock), .Resetn(Resetn), .start(start[1]), .clear(clear), .mode(mode),
    .a(a[3:0]), .b(b[3:0]), .busy(busy1), .done(done1), .sum(sum1),
    .carry_out(cout1), .error(err1), .inv_a(inva1), .inv_b(invb1));

  bcd_serial_adder #(.NDIGITS(8)) u_dut8 (
    .Clock(Clock), .Resetn(Resetn), .start(start[2]), .clear(clear), .mode(mode),
    .a(a), .b(b), .busy(busy8), .done(done8), .sum(sum8),
    .carry_out(cout8), .error(err8), .inv_a(inva8), .inv_b(invb8));

  logic [31:0] sumq [3];
  logic [7:0]  invaq [3];
  logic [7:0]  invbq [3];
  logic [2:0]  busyq, doneq, coutq, errq;

  assign sumq[0]  = 32'(sum4);
  assign sumq[1]  = 32'(sum1);
  assign sumq[2]  = sum8;
  assign invaq[0] = 8'(inva4);
  assign invaq[1] = 8'(inva1);
  assign invaq[2] = inva8;
  assign invbq[0] = 8'(invb4);
  assign invbq[1] = 8'(invb1);
  assign invbq[2] = invb8;
  assign busyq = {busy8, busy1, busy4};
  assign doneq = {done8, done1, done4};
  assign coutq = {cout8, cout1, cout4};
  assign errq  = {err8, err1, err4};

  int          nd [3] = '{4, 1, 8};
  logic [31:0] macc [3];
  bit          mcarry [3];
  int          tests = 0;
  int          fails = 0;

  // Reference arithmetic on decimal values, independent of any digit-serial structure.
  function automatic longint dec(input logic [31:0] x, input int n);
    longint v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [31:0] enc(input longint v, input int n);
    logic [31:0] r = '0;
    longint      t = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] inv_flags(input logic [31:0] x, input int n);
    logic [7:0] f = '0;
    for (int i = 0; i < n; i++) f[i] = (x[4*i +: 4] > 4'd9);
    return f;
  endfunction

  function automatic logic [31:0] rand_bcd(input int n, input bit allow_bad);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      if (allow_bad && $urandom_range(0, 11) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
      else                                          r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      macc[k]   = '0;
      mcarry[k] = 1'b0;
    end
  endtask

  task automatic op(input int k, input logic [31:0] ia_in, input logic [31:0] ib_in,
                    input bit im, input bit restart, input string nm);
    int          n;
    int          busyc;
    bit          held;
    logic [31:0] msk, ia, ib, opb, es;
    logic [7:0]  ea, eb;
    bit          ec, ee;
    longint      t, p;
    msk = (nd[k] == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * nd[k])) - 32'h1);
    ia  = ia_in & msk;
    ib  = ib_in & msk;
    opb = im ? macc[k] : ib;
    ea  = inv_flags(ia, nd[k]);
    eb  = im ? 8'h00 : inv_flags(ib, nd[k]);
    ee  = (ea != 0) || (eb != 0);
    p   = pow10(nd[k]);
    if (!ee) begin
      t  = dec(ia, nd[k]) + dec(opb, nd[k]);
      ec = (t >= p);
      es = enc(t % p, nd[k]);
    end else begin
      ec = mcarry[k];
      es = macc[k];
    end

    a = ia; b = ib; mode = im; start[k] = 1'b1;
    @(posedge Clock); #1;
    start[k] = 1'b0;
    n = 0; busyc = 0; held = 1'b1;
    while (!doneq[k] && n < 40) begin
      if (busyq[k]) busyc++;
      if (sumq[k] !== macc[k]) held = 1'b0;
      start[k] = restart && (n == 1);
      @(posedge Clock); #1;
      n++;
    end
    start[k] = 1'b0;

    tests++;
    if (n !== (ee ? 0 : nd[k])) begin
      fails++; $display("FAIL %s latency: got %0d cycles, expected %0d", nm, n, ee ? 0 : nd[k]);
    end
    tests++;
    if (busyc !== (ee ? 0 : nd[k])) begin
      fails++; $display("FAIL %s busy_cycles: got %0d, expected %0d", nm, busyc, ee ? 0 : nd[k]);
    end
    tests++;
    if (!held) begin
      fails++; $display("FAIL %s sum_hold: sum changed before done, expected %h", nm, macc[k]);
    end
    tests++;
    if (sumq[k] !== es) begin
      fails++; $display("FAIL %s sum: got %h, expected %h", nm, sumq[k], es);
    end
    tests++;
    if (coutq[k] !== ec) begin
      fails++; $display("FAIL %s carry_out: got %b, expected %b", nm, coutq[k], ec);
    end
    tests++;
    if (errq[k] !== ee) begin
      fails++; $display("FAIL %s error: got %b, expected %b", nm, errq[k], ee);
    end
    tests++;
    if (invaq[k] !== ea || invbq[k] !== eb) begin
      fails++; $display("FAIL %s inv: got a=%b b=%b, expected a=%b b=%b", nm, invaq[k], invbq[k], ea, eb);
    end
    if (!ee) begin
      macc[k]   = es;
      mcarry[k] = ec;
    end
    @(posedge Clock); #1;
    tests++;
    if (doneq[k] !== 1'b0 || busyq[k] !== 1'b0) begin
      fails++; $display("FAIL %s single_done: got done=%b busy=%b, expected 0 0", nm, doneq[k], busyq[k]);
    end
    $display("[TB] %s n=%0d a=%h b=%h mode=%0d -> sum=%h c=%b err=%b", nm, nd[k], ia, ib, im,
             sumq[k], coutq[k], errq[k]);
  endtask

  task automatic check_all_zero(input string nm);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (sumq[k] !== '0 || {busyq[k], doneq[k], coutq[k], errq[k]} !== 4'b0000 ||
          invaq[k] !== '0 || invbq[k] !== '0) begin
        fails++;
        $display("FAIL %s k=%0d: got sum=%h busy=%b done=%b c=%b err=%b inva=%b invb=%b, expected all 0",
                 nm, k, sumq[k], busyq[k], doneq[k], coutq[k], errq[k], invaq[k], invbq[k]);
      end
    end
  endtask

  task automatic test_reset();
    #2 Resetn = 1'b0;
    #1 check_all_zero("reset");
    @(posedge Clock); @(negedge Clock);
    Resetn = 1'b1;
    model_clear();
    @(posedge Clock); #1;
  endtask

  task automatic test_directed();
    op(0, 32'h1234, 32'h5678, 1'b0, 1'b0, "add_1234_5678");
    op(0, 32'h9999, 32'h0001, 1'b0, 1'b0, "add_overflow");
    op(0, 32'h0909, 32'h0909, 1'b0, 1'b0, "add_0909");
    op(0, 32'h12A4, 32'h00F0, 1'b0, 1'b0, "invalid_operand");
    op(1, 32'h7, 32'h5, 1'b0, 1'b0, "n1_add_7_5");
    op(1, 32'h9, 32'h9, 1'b0, 1'b0, "n1_add_9_9");
    op(1, 32'hB, 32'h1, 1'b0, 1'b0, "n1_invalid");
    op(2, 32'h9999_9999, 32'h0000_0001, 1'b0, 1'b0, "n8_overflow");
    op(2, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, "n8_add");
  endtask

  task automatic test_accumulate();
    clear = 1'b1;
    @(posedge Clock); #1;
    clear = 1'b0;
    model_clear();
    check_all_zero("acc_clear");
    op(0, 32'h0500, 32'h4444, 1'b1, 1'b0, "acc_1");
    op(0, 32'h0500, 32'h0000, 1'b1, 1'b0, "acc_2");
    op(0, 32'h0500, 32'hFFFF, 1'b1, 1'b0, "acc_3");
    op(0, 32'h9000, 32'h0000, 1'b1, 1'b0, "acc_wrap");
  endtask

  task automatic test_back_to_back();
    op(0, 32'h4321, 32'h1111, 1'b0, 1'b1, "restart_ignored");
    op(0, 32'h0002, 32'h0003, 1'b0, 1'b0, "back_to_back");
  endtask

  task automatic test_clear_abort();
    int dcnt;
    a = 32'h1111; b = 32'h2222; mode = 1'b0; start[0] = 1'b1;
    @(posedge Clock); #1;
    start[0] = 1'b0;
    @(posedge Clock); #1;
    clear = 1'b1;
    start[1] = 1'b1;
    @(posedge Clock); #1;
    clear = 1'b0;
    start[1] = 1'b0;
    model_clear();
    check_all_zero("clear_abort");
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (doneq != 3'b000 || busyq != 3'b000) dcnt++;
      @(posedge Clock); #1;
    end
    tests++;
    if (dcnt !== 0) begin
      fails++; $display("FAIL clear_no_done: got %0d active cycles, expected 0", dcnt);
    end
    op(0, 32'h0001, 32'h0001, 1'b0, 1'b0, "after_clear");
  endtask

  task automatic test_async_reset();
    a = 32'h9999; b = 32'h9999; mode = 1'b0; start[0] = 1'b1;
    @(posedge Clock); #1;
    start[0] = 1'b0;
    @(posedge Clock); #2;
    tests++;
    if (busyq[0] !== 1'b1) begin
      fails++; $display("FAIL arst_precondition: got busy=%b, expected 1", busyq[0]);
    end
    Resetn = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge Clock);
    Resetn = 1'b1;
    model_clear();
    @(posedge Clock); #1;
    op(0, 32'h0001, 32'h0001, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 15; i++) begin
        op(k, rand_bcd(nd[k], 1'b1), rand_bcd(nd[k], 1'b1), ($urandom_range(0, 2) == 0),
           1'b0, "random");
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_directed();
    test_accumulate();
    test_back_to_back();
    test_clear_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
